tuple_serializer: RTL and testbench

Consumer end of the generator output interface. Accepts 4-word signed tuples (_in0.._in3) from a generator module over a valid/ready handshake and buffers them in a tuple FIFO. Replays them as a single-word stream, one word per cycle, for downstream logging or display. Tracks the generator's completion and asserts _done once every accepted tuple has been emitted.

---
 rtl/tuple_serializer_if.sv | 27 ++
 rtl/tuple_serializer.sv | 142 ++++++++++++++
 tb/tb_tuple_serializer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tuple_serializer_if.sv
// tuple_serializer_if: tuple input handshake (4 signed words) and serialized word output stream.
// The serializer connects through the slave modport; the tuple generator / sink side uses master.
interface tuple_serializer_if #(
  parameter int WIDTH = 32
);
  logic signed [WIDTH-1:0] _in0;
  logic signed [WIDTH-1:0] _in1;
  logic signed [WIDTH-1:0] _in2;
  logic signed [WIDTH-1:0] _in3;
  logic                    _in_valid;
  logic                    _in_ready;
  logic                    _in_done;
  logic signed [WIDTH-1:0] _out;
  logic                    _out_valid;
  logic                    _out_ready;
  logic                    _out_last;

  modport master (
    output _in0, _in1, _in2, _in3, _in_valid, _in_done, _out_ready,
    input  _in_ready, _out, _out_valid, _out_last
  );

  modport slave (
    input  _in0, _in1, _in2, _in3, _in_valid, _in_done, _out_ready,
    output _in_ready, _out, _out_valid, _out_last
  );
endinterface

// File: rtl/tuple_serializer.sv
// tuple_serializer: buffers 4-word tuples in a FIFO and replays them one word per cycle.
// Define TUPLE_SERIALIZER_CHECKSUM_EN to add the running _checksum output.
module tuple_serializer #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   _clock,
  input  logic                   _reset,
  tuple_serializer_if.slave      bus,
  output logic [COUNT_WIDTH-1:0] _count,
  output logic                   _done
`ifdef TUPLE_SERIALIZER_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]       _checksum
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  typedef logic [3:0][WIDTH-1:0] tuple_t;
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  state_e                 state_q, state_d;
  tuple_t                 mem [DEPTH];
  tuple_t                 hold_q, hold_d;
  logic [1:0]             idx_q, idx_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]          occ_q, occ_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   done_seen_q, done_seen_d;
  logic                   push, pop, empty, out_fire;

  // Occupancy counts FIFO entries only; the holding register is one extra tuple of slack.
  assign empty          = (occ_q == '0);
  assign bus._in_ready  = !_reset && (occ_q < OW'(DEPTH)) && (state_q != DONE);
  assign push           = bus._in_valid && bus._in_ready;
  assign bus._out_valid = (state_q == SEND);
  assign bus._out_last  = (state_q == SEND) && (idx_q == 2'd3);
  assign bus._out       = hold_q[idx_q];
  assign out_fire       = bus._out_valid && bus._out_ready;
  assign _count         = count_q;
  assign _done          = (state_q == DONE);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    hold_d      = hold_q;
    idx_d       = idx_q;
    count_d     = count_q;
    done_seen_d = done_seen_q | bus._in_done;
    pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          hold_d  = mem[rd_ptr_q];
          idx_d   = 2'd0;
          state_d = SEND;
        end else if (done_seen_q) begin
          state_d = DONE;
        end
      end
      SEND: begin
        if (out_fire) begin
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
          end else begin
            if (count_q != '1) count_d = count_q + COUNT_WIDTH'(1);
            // Back-to-back tuples reload in the same edge so the stream has no bubble.
            if (!empty) begin
              pop    = 1'b1;
              hold_d = mem[rd_ptr_q];
              idx_d  = 2'd0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      DONE:    ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      occ_d = occ_q + OW'(1);
    else if (pop && !push) occ_d = occ_q - OW'(1);
  end

  always_ff @(posedge _clock) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (_reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      idx_q       <= 2'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      count_q     <= '0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      idx_q       <= idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      count_q     <= count_d;
      done_seen_q <= done_seen_d;
    end
  end

  // NOTE: the FIFO storage is not reset; the pointers and occupancy alone define its contents.
  always_ff @(posedge _clock) begin
    if (push) mem[wr_ptr_q] <= {bus._in3, bus._in2, bus._in1, bus._in0};
  end

`ifdef TUPLE_SERIALIZER_CHECKSUM_EN
  logic [WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (out_fire) sum_d = sum_q + bus._out;
  end

  always_ff @(posedge _clock) begin
    if (_reset) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign _checksum = sum_q;
`endif

endmodule

// File: tb/tb_tuple_serializer.sv
// tb_tuple_serializer: scoreboard bench for tuple_serializer with directed and random traffic.
`timescale 1ns/1ps
module tb_tuple_serializer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 16;

  typedef logic signed [WIDTH-1:0] word_t;
  typedef struct {
    word_t word;
    logic  last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] count;
  logic          done;
`ifdef TUPLE_SERIALIZER_CHECKSUM_EN
  logic [WIDTH-1:0] checksum;
`endif

  tuple_serializer_if #(.WIDTH(WIDTH)) bus ();

  tuple_serializer #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .COUNT_WIDTH(CW)
  ) dut (
    ._clock(clk),
    ._reset(rst),
    .bus(bus),
    ._count(count),
    ._done(done)
`ifdef TUPLE_SERIALIZER_CHECKSUM_EN
    ,
    ._checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int               n_tests = 0;
  int               n_fail = 0;
  int               cyc = 0;
  int               hs_count = 0;
  int               last_hs_cyc = 0;
  exp_t             exp_q[$];
  logic [WIDTH-1:0] model_sum = '0;
  int               rdy_mode = 0;
  logic             rdy_val = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Downstream ready: constant, toggling, or random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus._out_ready = rdy_val;
      1:       bus._out_ready = ~bus._out_ready;
      default: bus._out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every handshaked word is compared with the front of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
`ifdef TUPLE_SERIALIZER_CHECKSUM_EN
      check("checksum_running", checksum, model_sum);
`endif
      if (bus._out_valid && bus._out_ready) begin
        hs_count++;
        last_hs_cyc = cyc;
        model_sum   = model_sum + bus._out;
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_word", bus._out, e.word);
          check("out_last", bus._out_last, e.last);
        end
      end
    end
  end

  // One offer cycle; an accepted tuple enters the scoreboard as four words.
  task automatic offer(input word_t w0, input word_t w1, input word_t w2, input word_t w3,
                       input logic dn, output bit acc);
    bus._in0 = w0; bus._in1 = w1; bus._in2 = w2; bus._in3 = w3;
    bus._in_valid = 1'b1;
    bus._in_done  = dn;
    @(negedge clk);
    acc = bus._in_ready;
    if (acc) begin
      exp_q.push_back(exp_t'{w0, 1'b0});
      exp_q.push_back(exp_t'{w1, 1'b0});
      exp_q.push_back(exp_t'{w2, 1'b0});
      exp_q.push_back(exp_t'{w3, 1'b1});
    end
    @(posedge clk);
    #1;
    bus._in_valid = 1'b0;
    bus._in_done  = 1'b0;
  endtask

  task automatic push_tuple(input word_t w0, input word_t w1, input word_t w2, input word_t w3,
                            input logic dn);
    bit acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) offer(w0, w1, w2, w3, dn, acc);
    if (!acc) check("push_timeout", 0, 1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus._out_valid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drain_pending"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus._in_valid = 1'b0;
    bus._in_done  = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus._in_ready, 0);
    @(posedge clk);
    #1;
    check("rst_out", bus._out, 0);
    check("rst_out_valid", bus._out_valid, 0);
    check("rst_out_last", bus._out_last, 0);
    check("rst_count", count, 0);
    check("rst_done", done, 0);
`ifdef TUPLE_SERIALIZER_CHECKSUM_EN
    check("rst_checksum", checksum, 0);
`endif
    exp_q.delete();
    model_sum = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit    acc;
    int    n_acc;
    int    base;
    int    n;
    word_t w[4];
    word_t t2_w0;

    bus._in0 = '0; bus._in1 = '0; bus._in2 = '0; bus._in3 = '0;
    bus._in_valid  = 1'b0;
    bus._in_done   = 1'b0;
    bus._out_ready = 1'b1;

    do_reset();

    // Single tuple: two-cycle latency, order, last flag, count.
    offer(23, 17, 5, 0, 1'b0, acc);
    check("t1_accept", acc, 1);
    check("t1_no_word_n1", bus._out_valid, 0);
    @(posedge clk);
    #1;
    check("t1_valid_n2", bus._out_valid, 1);
    check("t1_word0_n2", bus._out, 23);
    drain("t1");
    check("t1_count", count, 1);
`ifdef TUPLE_SERIALIZER_CHECKSUM_EN
    check("t6_checksum_4", checksum, 45);
`endif
    push_tuple(-1, 1, 0, 0, 1'b0);
    drain("t6");
    check("t6_count", count, 2);
`ifdef TUPLE_SERIALIZER_CHECKSUM_EN
    check("t6_checksum_8", checksum, 45);
`endif

    // Backpressure fill: DEPTH + 1 tuples fit, output held stable.
    rdy_val = 1'b0;
    @(posedge clk);
    #1;
    n_acc = 0;
    t2_w0 = '0;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 4; j++) w[j] = word_t'($urandom);
      if (i == 0) t2_w0 = w[0];
      offer(w[0], w[1], w[2], w[3], 1'b0, acc);
      if (acc) n_acc++;
      if (i == 9) check("t2_tenth_refused", acc, 0);
      if (i >= 1) check("t2_out_stable", bus._out, t2_w0);
    end
    check("t2_accepted", n_acc, 9);
    check("t2_in_ready_full", bus._in_ready, 0);
    check("t2_valid_held", bus._out_valid, 1);
    check("t2_last_held", bus._out_last, 0);
    rdy_val = 1'b1;
    drain("t2");
    check("t2_count", count, 11);

    // Toggling ready: eight words, in order, no drops or duplicates.
    rdy_mode = 1;
    base = hs_count;
    push_tuple(1, 2, 3, 4, 1'b0);
    push_tuple(5, 6, 7, 8, 1'b0);
    drain("t3");
    check("t3_words", hs_count - base, 8);
    rdy_mode = 0;
    check("t3_count", count, 13);

    // Random traffic with random ready and random gaps.
    rdy_mode = 2;
    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < 4; j++) w[j] = word_t'($urandom);
      push_tuple(w[0], w[1], w[2], w[3], 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rdy_mode = 0;
    rdy_val  = 1'b1;
    drain("rnd");
    check("rnd_count", count, 33);

    // Completion: _in_done with the third push, _done two edges after final handshake.
    do_reset();
    push_tuple(10, -20, 30, -40, 1'b0);
    push_tuple(50, 60, 70, 80, 1'b0);
    push_tuple(-90, 100, -110, 120, 1'b1);
    drain("t4");
    n = 0;
    while (cyc < last_hs_cyc + 1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("t4_done_after_1_edge", done, 0);
    @(negedge clk);
    check("t4_done_after_2_edges", done, 1);
    repeat (5) @(negedge clk);
    check("t4_done_sticky", done, 1);
    check("t4_count", count, 3);
    @(posedge clk);
    #1;
    offer(1, 1, 1, 1, 1'b0, acc);
    check("t4_refuse_after_done", acc, 0);
    repeat (3) @(negedge clk);
    check("t4_no_output_after_done", bus._out_valid, 0);
    check("t4_done_still", done, 1);
    @(posedge clk);
    #1;

    // Reset in the middle of a tuple, then resume from an empty FIFO.
    do_reset();
    push_tuple(23, 17, 5, 0, 1'b0);
    base = hs_count;
    n = 0;
    while (hs_count < base + 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t5_two_words", hs_count - base, 2);
    do_reset();
    push_tuple(1, 2, 3, 4, 1'b0);
    drain("t5");
    check("t5_count", count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
